hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised operand-forwarding and hazard unit for the 5-stage RISC-V core.
//  Resolves NUM_SRC source operands of the instruction in ID against in-flight
//  destinations in EX/MEM/WB and registers the resolved operands into ID/EX.
//  Generates the load-use stall and flush bubble. Mode FWD_EN=0 gives a
//  stall-only (no bypass) pipeline for debug/area builds.
// PARAMETERS
//  XLEN     32  operand/result width
//  NUM_SRC  2   source operands per instruction (1..3)
//  FWD_EN   1   1: bypass EX/MEM/WB results; 0: stall until producer retires
// PORTS
//  clk           in   1            core clock, all state on rising edge
//  rst_n         in   1            asynchronous reset, active low
//  id_valid      in   1            valid instruction in ID
//  id_rs_addr    in   5*NUM_SRC    source reg indices, src i at [5i+4:5i]
//  id_rs_data    in   XLEN*NUM_SRC register-file read data, src i at [XLEN*i +: XLEN]
//  id_rd_addr    in   5            destination index of ID instruction
//  id_rd_we      in   1            ID instruction writes rd
//  id_is_load    in   1            ID instruction is a load
//  ex_result     in   XLEN         ALU result of instruction now in EX (combinational)
//  mem_result    in   XLEN         result of instruction now in MEM (load data incl.)
//  wb_result     in   XLEN         value being written back this cycle
//  flush         in   1            kill instruction in ID (branch redirect)
//  stall         out  1            hold PC and IF/ID this cycle (combinational)
//  ex_valid      out  1            ID/EX register holds a live instruction
//  ex_operand    out  XLEN*NUM_SRC registered resolved operands
//  fwd_sel       out  2*NUM_SRC    per-src source select (comb): 00 RF,01 EX,10 MEM,11 WB
// BEHAVIOUR
//  - Internal tags T_ex,T_mem,T_wb = {valid,rd,we,is_load}; live(T) = valid & we & rd!=0.
//  - Reset (rst_n=0, async): all tags invalid, ex_valid=0, ex_operand=0; hence stall=0,
//    fwd_sel=00. Reset mid-stall drops the stall immediately; no partial state survives.
//  - match_X(i) = id_valid & live(T_X) & T_X.rd==rs_addr[i]. rs=x0 never matches
//    (operand taken from RF, which reads 0).
//  - FWD_EN=1: sel(i) priority EX > MEM > WB > RF; stall = OR_i match_ex(i) & T_ex.is_load.
//  - FWD_EN=0: sel(i)=RF always; stall = OR_i (match_ex|match_mem|match_wb)(i).
//    RF has no write-through: WB match stalls.
//  - flush forces stall=0 and is the highest-priority event.
//  - Rising edge, in priority order:
//    flush:        T_ex<=invalid, ex_valid<=0, ex_operand held; T_mem<=T_ex, T_wb<=T_mem.
//    stall:        bubble, same as flush; ID held by upstream.
//    else:         T_ex<=ID fields (valid=id_valid), ex_valid<=id_valid,
//                  ex_operand[i]<=selected source if id_valid else held; T_mem<=T_ex; T_wb<=T_mem.
//  - Latency: resolved operand visible at ex_operand 1 cycle after the ID cycle accepted.
//    Load-use costs exactly 1 bubble (FWD_EN=1). Stall-only mode costs up to 3 bubbles.
//  - Multiple srcs may match different stages; each resolves independently.
//    Same rd in EX and MEM: the younger (EX) wins.
//  - Widths: all datapath exact XLEN, no extension; rd/rs fixed 5 bits.
// TESTING
//  1 reset: rst_n=0 mid-stream with id_valid=1 -> ex_valid=0, ex_operand=0, stall=0 immediately.
//  2 EX fwd: add x5 in EX, ex_result=0x1234, ID rs1=x5 rs_data=0 -> fwd_sel[1:0]=01,
//    next cycle ex_operand[31:0]=0x1234.
//  3 priority: x7 in EX (0xAAAA) and MEM (0xBBBB), ID rs1=rs2=x7 -> both ops 0xAAAA;
//    rs=x0 with x0 "writer" in EX -> RF value 0.
//  4 load-use: lw x3 in EX, ID rs2=x3 -> stall=1 one cycle, ex_valid=0 next;
//    then fwd_sel=10, ex_operand src1 = mem_result 0xDEADBEEF.
//  5 flush during load-use stall -> stall=0 same cycle, ex_valid=0 next, tags advance.
//  6 FWD_EN=0, NUM_SRC=3, XLEN=64: ID rs3 depends on EX producer -> stall 3 cycles,
//    then RF data captured with fwd_sel=00.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use hazard unit between ID and EX.
// One hfu_src_resolve instance per source operand; tags for EX/MEM/WB shift every cycle.
module hfu_src_resolve #(
   parameter int XLEN   = 32,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            id_valid,
   input  logic [4:0]      rs_addr,
   input  logic [XLEN-1:0] rs_data,
   input  logic            ex_live,
   input  logic [4:0]      ex_rd,
   input  logic            ex_load,
   input  logic            mem_live,
   input  logic [4:0]      mem_rd,
   input  logic            wb_live,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] mem_result,
   input  logic [XLEN-1:0] wb_result,
   output logic [1:0]      sel,
   output logic [XLEN-1:0] opnd,
   output logic            hazard
);
   logic m_ex, m_mem, m_wb;

   // live() already excludes rd==0, so an x0 source can never match
   assign m_ex  = id_valid & ex_live  & (ex_rd  == rs_addr);
   assign m_mem = id_valid & mem_live & (mem_rd == rs_addr);
   assign m_wb  = id_valid & wb_live  & (wb_rd  == rs_addr);

   always_comb begin
      sel    = 2'b00;
      opnd   = rs_data;
      hazard = 1'b0;
      if (FWD_EN) begin
         hazard = m_ex & ex_load;
         if (m_ex) begin
            sel  = 2'b01;
            opnd = ex_result;
         end else if (m_mem) begin
            sel  = 2'b10;
            opnd = mem_result;
         end else if (m_wb) begin
            sel  = 2'b11;
            opnd = wb_result;
         end
      end else begin
         hazard = m_ex | m_mem | m_wb;
      end
   end
endmodule

module hazard_forward_unit #(
   parameter int XLEN    = 32,
   parameter int NUM_SRC = 2,
   parameter bit FWD_EN  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    id_valid,
   input  logic [5*NUM_SRC-1:0]    id_rs_addr,
   input  logic [XLEN*NUM_SRC-1:0] id_rs_data,
   input  logic [4:0]              id_rd_addr,
   input  logic                    id_rd_we,
   input  logic                    id_is_load,
   input  logic [XLEN-1:0]         ex_result,
   input  logic [XLEN-1:0]         mem_result,
   input  logic [XLEN-1:0]         wb_result,
   input  logic                    flush,
   output logic                    stall,
   output logic                    ex_valid,
   output logic [XLEN*NUM_SRC-1:0] ex_operand,
   output logic [2*NUM_SRC-1:0]    fwd_sel
);
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       is_load;
   } tag_t;

   // tag_pipe[0]=EX, [1]=MEM, [2]=WB
   tag_t [2:0]                   tag_pipe;
   logic [2:0]                   live;
   logic [NUM_SRC-1:0][XLEN-1:0] res_op;
   logic [NUM_SRC-1:0][XLEN-1:0] op_q;
   logic [NUM_SRC-1:0]           hazard;

   for (genvar s = 0; s < 3; s++) begin : g_live
      assign live[s] = tag_pipe[s].valid & tag_pipe[s].we & (tag_pipe[s].rd != 5'd0);
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hfu_src_resolve #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_src (
         .id_valid   (id_valid),
         .rs_addr    (id_rs_addr[5*i +: 5]),
         .rs_data    (id_rs_data[XLEN*i +: XLEN]),
         .ex_live    (live[0]),
         .ex_rd      (tag_pipe[0].rd),
         .ex_load    (tag_pipe[0].is_load),
         .mem_live   (live[1]),
         .mem_rd     (tag_pipe[1].rd),
         .wb_live    (live[2]),
         .wb_rd      (tag_pipe[2].rd),
         .ex_result  (ex_result),
         .mem_result (mem_result),
         .wb_result  (wb_result),
         .sel        (fwd_sel[2*i +: 2]),
         .opnd       (res_op[i]),
         .hazard     (hazard[i])
      );
   end

   assign stall      = ~flush & (|hazard);
   assign ex_valid   = tag_pipe[0].valid;
   assign ex_operand = op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_pipe <= '0;
         op_q     <= '0;
      end else begin
         tag_pipe[2] <= tag_pipe[1];
         tag_pipe[1] <= tag_pipe[0];
         if (flush || stall) begin
            tag_pipe[0] <= '0;
         end else begin
            tag_pipe[0] <= {id_valid, id_rd_addr, id_rd_we, id_is_load};
            if (id_valid) op_q <= res_op;
         end
      end
   end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a forwarding build (d0) and a stall-only
// 64-bit three-source build (d1), both checked each cycle against a pipeline-history model.
module tb_hazard_forward_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv[2];
   logic [4:0]  ra[2][3];
   logic [63:0] rdat[2][3];
   logic [4:0]  rd[2];
   logic        we[2], ld[2], fl[2];
   logic [63:0] exr[2], memr[2], wbr[2];

   logic         st[2], ev[2];
   logic [3:0]   fs0;
   logic [63:0]  eo0;
   logic [5:0]   fs1;
   logic [191:0] eo1;

   int checks = 0;
   int failures = 0;

   hazard_forward_unit #(.XLEN(32), .NUM_SRC(2), .FWD_EN(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_valid(iv[0]),
      .id_rs_addr({ra[0][1], ra[0][0]}),
      .id_rs_data({rdat[0][1][31:0], rdat[0][0][31:0]}),
      .id_rd_addr(rd[0]), .id_rd_we(we[0]), .id_is_load(ld[0]),
      .ex_result(exr[0][31:0]), .mem_result(memr[0][31:0]), .wb_result(wbr[0][31:0]),
      .flush(fl[0]), .stall(st[0]), .ex_valid(ev[0]), .ex_operand(eo0), .fwd_sel(fs0));

   hazard_forward_unit #(.XLEN(64), .NUM_SRC(3), .FWD_EN(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(iv[1]),
      .id_rs_addr({ra[1][2], ra[1][1], ra[1][0]}),
      .id_rs_data({rdat[1][2], rdat[1][1], rdat[1][0]}),
      .id_rd_addr(rd[1]), .id_rd_we(we[1]), .id_is_load(ld[1]),
      .ex_result(exr[1]), .mem_result(memr[1]), .wb_result(wbr[1]),
      .flush(fl[1]), .stall(st[1]), .ex_valid(ev[1]), .ex_operand(eo1), .fwd_sel(fs1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Model: history of the last three accepted slots (0 = EX, 1 = MEM, 2 = WB)
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } mtag_t;
   mtag_t     mt[2][3];
   bit [63:0] mop[2][3];
   bit        e_stall[2];
   bit [1:0]  e_sel[2][3];
   bit [63:0] e_val[2][3];

   function automatic bit [63:0] msk(int d, bit [63:0] x);
      return (d == 0) ? {32'b0, x[31:0]} : x;
   endfunction

   function automatic void calc(int d);
      int n;
      int y;
      n = (d == 0) ? 2 : 3;
      e_stall[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e_sel[d][i] = 2'b00;
         e_val[d][i] = msk(d, rdat[d][i]);
         if (i >= n || !iv[d] || ra[d][i] == 5'd0) continue;
         y = -1;
         // scan oldest to youngest so the youngest producer is kept
         for (int k = 2; k >= 0; k--)
            if (mt[d][k].v && mt[d][k].we && mt[d][k].rd == ra[d][i]) y = k;
         if (y < 0) continue;
         if (d == 0) begin
            if (y == 0 && mt[d][0].ld) e_stall[d] = 1'b1;
            e_sel[d][i] = 2'(y + 1);
            e_val[d][i] = msk(d, (y == 0) ? exr[d] : (y == 1) ? memr[d] : wbr[d]);
         end else begin
            e_stall[d] = 1'b1;
         end
      end
      if (fl[d]) e_stall[d] = 1'b0;
   endfunction

   function automatic void commit(int d);
      mt[d][2] = mt[d][1];
      mt[d][1] = mt[d][0];
      if (fl[d] || e_stall[d]) begin
         mt[d][0] = '{1'b0, 5'd0, 1'b0, 1'b0};
      end else begin
         mt[d][0] = '{iv[d], rd[d], we[d], ld[d]};
         if (iv[d]) for (int i = 0; i < 3; i++) mop[d][i] = e_val[d][i];
      end
   endfunction

   function automatic logic [63:0] get_op(int d, int i);
      return (d == 0) ? {32'b0, eo0[32*i +: 32]} : eo1[64*i +: 64];
   endfunction

   function automatic logic [1:0] get_sel(int d, int i);
      return (d == 0) ? fs0[2*i +: 2] : fs1[2*i +: 2];
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n)
               for (int k = 0; k < 3; k++) begin
                  mt[d][k] = '{1'b0, 5'd0, 1'b0, 1'b0};
                  mop[d][k] = '0;
               end
            calc(d);
            chk($sformatf("d%0d_stall", d), 64'(st[d]), 64'(e_stall[d]));
            chk($sformatf("d%0d_ex_valid", d), 64'(ev[d]), 64'(mt[d][0].v));
            for (int i = 0; i < ((d == 0) ? 2 : 3); i++) begin
               chk($sformatf("d%0d_fwd_sel%0d", d, i), 64'(get_sel(d, i)), 64'(e_sel[d][i]));
               chk($sformatf("d%0d_ex_operand%0d", d, i), get_op(d, i), mop[d][i]);
            end
         end
         @(posedge clk);
         if (rst_n) for (int d = 0; d < 2; d++) commit(d);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idl(input int d);
      iv[d] = 1'b0; rd[d] = '0; we[d] = 1'b0; ld[d] = 1'b0; fl[d] = 1'b0;
      exr[d] = '0; memr[d] = '0; wbr[d] = '0;
      for (int i = 0; i < 3; i++) begin
         ra[d][i] = '0;
         rdat[d][i] = '0;
      end
   endtask

   task automatic id(input int d, input bit v, input bit [4:0] rdv, input bit wev, input bit ldv,
                     input bit [4:0] a0, input bit [4:0] a1, input bit [4:0] a2,
                     input bit [63:0] d0, input bit [63:0] d1, input bit [63:0] d2);
      iv[d] = v; rd[d] = rdv; we[d] = wev; ld[d] = ldv;
      ra[d][0] = a0; ra[d][1] = a1; ra[d][2] = a2;
      rdat[d][0] = d0; rdat[d][1] = d1; rdat[d][2] = d2;
   endtask

   initial begin
      idl(0);
      idl(1);
      repeat (2) cyc();
      chk("rst_ex_valid", 64'(ev[0]), 64'd0);
      chk("rst_stall", 64'(st[0]), 64'd0);
      chk("rst_fwd_sel", 64'(fs0), 64'd0);
      rst_n = 1'b1;

      // EX forward
      cyc(); id(0, 1, 5, 1, 0, 1, 2, 0, 64'h10, 64'h20, 0);
      cyc(); id(0, 1, 6, 1, 0, 5, 0, 0, 0, 0, 0); exr[0] = 64'h1234;
      #1 chk("ex_fwd_sel", 64'(fs0[1:0]), 64'h1);
      cyc(); chk("ex_fwd_op", 64'(eo0[31:0]), 64'h1234);

      // EX over MEM priority, then x0 writer ignored
      id(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 0, 1, 0, 7, 7, 0, 64'h1, 64'h2, 0);
      exr[0] = 64'hAAAA; memr[0] = 64'hBBBB;
      #1 chk("prio_sel", 64'(fs0), 64'h5);
      cyc(); chk("prio_op", eo0, 64'h0000AAAA_0000AAAA);
      id(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0); exr[0] = 64'h5555;
      #1 chk("x0_sel", 64'(fs0), 64'h0);
      cyc(); chk("x0_op", eo0, 64'h0);

      // sources resolved from different stages (WB and MEM)
      id(0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 0, 0, 0, 10, 11, 0, 64'h7, 64'h8, 0);
      memr[0] = 64'h11110000; wbr[0] = 64'hA0A0;
      #1 chk("mix_sel", 64'(fs0), 64'hB);
      cyc(); chk("mix_op", eo0, 64'h11110000_0000A0A0);

      // load-use: one bubble then MEM forward
      id(0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 4, 1, 0, 1, 3, 0, 64'h11, 64'h0, 0);
      #1 chk("lu_stall", 64'(st[0]), 64'd1);
      cyc(); chk("lu_bubble", 64'(ev[0]), 64'd0);
      memr[0] = 64'hDEADBEEF;
      #1 chk("lu_stall_done", 64'(st[0]), 64'd0);
      chk("lu_sel", 64'(fs0[3:2]), 64'h2);
      cyc(); chk("lu_op", eo0, 64'hDEADBEEF_00000011);
      chk("lu_valid", 64'(ev[0]), 64'd1);

      // flush during load-use stall
      id(0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 4, 1, 0, 3, 0, 0, 0, 0, 0);
      #1 chk("fl_pre_stall", 64'(st[0]), 64'd1);
      fl[0] = 1'b1;
      #1 chk("fl_stall", 64'(st[0]), 64'd0);
      cyc(); chk("fl_bubble", 64'(ev[0]), 64'd0);
      fl[0] = 1'b0; memr[0] = 64'hCAFE0000;
      #1 chk("fl_adv_sel", 64'(fs0[1:0]), 64'h2);
      chk("fl_adv_stall", 64'(st[0]), 64'd0);
      cyc(); chk("fl_adv_op", 64'(eo0[31:0]), 64'hCAFE0000);

      // asynchronous reset in the middle of a load-use stall
      id(0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc(); id(0, 1, 4, 1, 0, 3, 0, 0, 0, 0, 0);
      #1 chk("rs_pre_stall", 64'(st[0]), 64'd1);
      rst_n = 1'b0;
      #1 chk("rs_stall", 64'(st[0]), 64'd0);
      chk("rs_valid", 64'(ev[0]), 64'd0);
      chk("rs_op", eo0, 64'd0);
      cyc(); idl(0); rst_n = 1'b1;

      // stall-only build: rs3 waits for the producer to retire
      cyc(); id(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(); id(1, 1, 20, 1, 0, 1, 2, 9, 64'h111, 64'h222, 64'h01234567_89ABCDEF);
      exr[1] = 64'hFFFF; memr[1] = 64'hEEEE; wbr[1] = 64'hDDDD;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("so_stall%0d", k), 64'(st[1]), 64'd1);
         cyc();
      end
      #1 chk("so_stall_done", 64'(st[1]), 64'd0);
      chk("so_sel", 64'(fs1), 64'h0);
      cyc(); chk("so_op3", eo1[191:128], 64'h01234567_89ABCDEF);
      chk("so_op1", eo1[63:0], 64'h111);
      chk("so_valid", 64'(ev[1]), 64'd1);

      idl(0);
      idl(1);
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
